// File: rtl/calc_pkg.sv
// Shared definitions for the arith_calc_seq calculator slice.
//   - opcode codes (OP_ADD..OP_XOR); codes >= NUM_OPS are invalid
//   - FSM state encoding of the top level (state_t)
//   - iteration modes of the shared shift/subtract unit (iter_mode_t)
//   - is_valid_op(): true for the defined opcodes
package calc_pkg;

  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_MUL  = 2;
  localparam int unsigned OP_DIV  = 3;
  localparam int unsigned OP_GCD  = 4;
  localparam int unsigned OP_AND  = 5;
  localparam int unsigned OP_OR   = 6;
  localparam int unsigned OP_XOR  = 7;
  localparam int unsigned NUM_OPS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    IT_MUL = 2'd0,
    IT_DIV = 2'd1,
    IT_GCD = 2'd2
  } iter_mode_t;

  function automatic logic is_valid_op(input int unsigned op);
    return op < NUM_OPS;
  endfunction

endpackage

// File: rtl/calc_if.sv
// Command/response bundle between the command decoder (master) and the
// calculator core (slave).
//   start/opcode/operand_a/operand_b : request, master -> slave
//   busy/result/done/error           : response, slave -> master
//   state_dbg                        : current FSM state, for observation
// Handshake: start is sampled only while the core is in IDLE; a high start
// at such an edge is the acceptance and latches opcode and operands. start
// seen in EXEC or FIN (busy, or the done cycle) is dropped, not queued. done
// is a one-cycle pulse; result/error stay valid from done until the next
// acceptance.
interface calc_if #(
  parameter int W    = 8,
  parameter int OP_W = 4
);
  import calc_pkg::*;

  logic            start;
  logic [OP_W-1:0] opcode;
  logic [W-1:0]    operand_a;
  logic [W-1:0]    operand_b;
  logic            busy;
  logic [2*W-1:0]  result;
  logic            done;
  logic            error;
  state_t          state_dbg;

  modport master (
    output start, opcode, operand_a, operand_b,
    input  busy, result, done, error, state_dbg
  );

  modport slave (
    input  start, opcode, operand_a, operand_b,
    output busy, result, done, error, state_dbg
  );

endinterface

// File: rtl/calc_iter_unit.sv
// Shared iterative datapath for MUL, DIV and GCD.
//   load  : start a new run with mode/a/b (a,b are magnitudes for MUL)
//   fin   : high for the single cycle in which res is final
//   res   : MUL {hi,lo} product, DIV {quotient,remainder}, GCD {0,gcd}
// MUL and DIV take exactly W steps; GCD runs until u==v. GCD inputs must be
// nonzero (the top resolves zero operands without iterating).
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  iter_mode_t     mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           fin,
  output logic [2*W-1:0] res
);
  localparam int CNT_W = $clog2(W + 1);

  // hi/lo: MUL partial product/multiplier, DIV remainder/quotient, GCD u/v
  logic [W-1:0]     hi, lo, m;
  logic [CNT_W-1:0] cnt, tz;
  iter_mode_t       mode_q;
  logic             running;
  logic [W:0]       add_sum, sub_shift;
  logic             sub_ok, step_done;
  logic [W-1:0]     gcd_val;

  always_comb begin
    add_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    sub_shift = {hi, lo[W-1]};
    sub_ok    = sub_shift >= {1'b0, m};
    // common factors of two removed along the way are restored here
    gcd_val   = hi << tz;
    step_done = (mode_q == IT_GCD) ? (hi == lo) : (cnt == '0);
  end

  assign fin = running && step_done;

  always_comb begin
    case (mode_q)
      IT_MUL:  res = {hi, lo};
      IT_DIV:  res = {lo, hi};
      default: res = {{W{1'b0}}, gcd_val};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running <= 1'b0;
      mode_q  <= IT_MUL;
      hi      <= '0;
      lo      <= '0;
      m       <= '0;
      cnt     <= '0;
      tz      <= '0;
    end else if (load) begin
      running <= 1'b1;
      mode_q  <= mode;
      m       <= b;
      cnt     <= CNT_W'(W);
      tz      <= '0;
      if (mode == IT_GCD) begin
        hi <= a;
        lo <= b;
      end else begin
        hi <= '0;
        lo <= a;
      end
    end else if (running) begin
      if (step_done) begin
        running <= 1'b0;
      end else begin
        case (mode_q)
          IT_MUL: begin
            // add multiplicand if LSB set, then shift the whole product right
            {hi, lo} <= {add_sum, lo[W-1:1]};
            cnt      <= cnt - 1'b1;
          end
          IT_DIV: begin
            hi  <= sub_ok ? W'(sub_shift - {1'b0, m}) : sub_shift[W-1:0];
            lo  <= {lo[W-2:0], sub_ok};
            cnt <= cnt - 1'b1;
          end
          default: begin
            // subtract and halve fused in one step keeps the run within ~2W steps
            if (!hi[0] && !lo[0]) begin
              hi <= hi >> 1;
              lo <= lo >> 1;
              tz <= tz + 1'b1;
            end else if (!hi[0]) begin
              hi <= hi >> 1;
            end else if (!lo[0]) begin
              lo <= lo >> 1;
            end else if (hi > lo) begin
              hi <= (hi - lo) >> 1;
            end else begin
              lo <= (lo - hi) >> 1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/arith_calc_seq.sv
// Multi-cycle calculator core, W-bit operands, 2W-bit result.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : calc_if slave (start/opcode/operands in; busy/result/done/
//                error/state_dbg out)
// FSM IDLE -> EXEC -> FIN -> IDLE. The first EXEC cycle either resolves the
// op directly (ADD/SUB/logic, invalid opcode, DIV by 0, GCD with a zero
// operand) or launches calc_iter_unit; FIN is the done cycle.
module arith_calc_seq
  import calc_pkg::*;
#(
  parameter int W    = 8,
  parameter int OP_W = 4
) (
  input logic    clk,
  input logic    rst_n,
  calc_if.slave  bus
);
  localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [OP_W-1:0] op_q;
  logic [W-1:0]    a_q, b_q;
  logic            first_q, fast_q;
  logic [2*W-1:0]  result_q;
  logic            error_q;

  int unsigned     op_idx;
  logic            iterative, fast_err, neg, unit_load, unit_fin;
  logic [2*W-1:0]  fast_res, unit_res, mul_signed;
  logic [W:0]      add_sum, sub_sum;
  iter_mode_t      unit_mode;
  logic [W-1:0]    unit_a, unit_b;

  assign op_idx = 32'(op_q);

  // Decode of the latched command: single-cycle result or iterative launch
  always_comb begin
    add_sum   = {1'b0, a_q} + {1'b0, b_q};
    sub_sum   = {1'b0, a_q} + {1'b0, ~b_q} + ONE;
    fast_res  = '0;
    fast_err  = 1'b0;
    iterative = 1'b0;
    unit_mode = IT_MUL;
    unit_a    = a_q;
    unit_b    = b_q;
    if (!is_valid_op(op_idx)) begin
      fast_err = 1'b1;
    end else begin
      case (op_idx)
        OP_ADD: fast_res = {{(W-1){1'b0}}, add_sum};
        OP_SUB: fast_res = {{(W-1){1'b0}}, sub_sum};
        OP_MUL: begin
          iterative = 1'b1;
          unit_mode = IT_MUL;
          unit_a    = a_q[W-1] ? -a_q : a_q;
          unit_b    = b_q[W-1] ? -b_q : b_q;
        end
        OP_DIV: begin
          if (b_q == '0) fast_err = 1'b1;
          else begin
            iterative = 1'b1;
            unit_mode = IT_DIV;
          end
        end
        OP_GCD: begin
          if (a_q == '0 && b_q == '0) fast_err = 1'b1;
          else if (a_q == '0)         fast_res = {{W{1'b0}}, b_q};
          else if (b_q == '0)         fast_res = {{W{1'b0}}, a_q};
          else begin
            iterative = 1'b1;
            unit_mode = IT_GCD;
          end
        end
        OP_AND:  fast_res = {{W{1'b0}}, a_q & b_q};
        OP_OR:   fast_res = {{W{1'b0}}, a_q | b_q};
        OP_XOR:  fast_res = {{W{1'b0}}, a_q ^ b_q};
        default: fast_err = 1'b1;
      endcase
    end
    // product is built on magnitudes; sign goes on as it is captured
    neg        = a_q[W-1] ^ b_q[W-1];
    mul_signed = neg ? -unit_res : unit_res;
  end

  calc_iter_unit #(.W(W)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (unit_load),
    .mode  (unit_mode),
    .a     (unit_a),
    .b     (unit_b),
    .fin   (unit_fin),
    .res   (unit_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unit_load = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (first_q)                  unit_load = iterative;
        else if (fast_q || unit_fin)  state_nxt = ST_FIN;
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      first_q  <= 1'b0;
      fast_q   <= 1'b0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (bus.start) begin
        op_q    <= bus.opcode;
        a_q     <= bus.operand_a;
        b_q     <= bus.operand_b;
        first_q <= 1'b1;
        fast_q  <= 1'b0;
        error_q <= 1'b0;
      end
    end else if (state == ST_EXEC) begin
      if (first_q) begin
        first_q <= 1'b0;
        if (!iterative) begin
          fast_q   <= 1'b1;
          result_q <= fast_res;
          error_q  <= fast_err;
        end
      end else if (unit_fin) begin
        result_q <= (op_idx == OP_MUL) ? mul_signed : unit_res;
      end
    end
  end

  assign bus.busy      = (state == ST_EXEC);
  assign bus.done      = (state == ST_FIN);
  assign bus.result    = result_q;
  assign bus.error     = error_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_arith_calc_seq.sv
module tb_arith_calc_seq;
  import calc_pkg::*;

  localparam int W8   = 8;
  localparam int W4   = 4;
  localparam int OP_W = 4;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic        err;
    int          lat;
    bit          lat_max;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q8[$];
  exp_t exp_q4[$];
  exp_t e8, e4;

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  calc_if #(.W(W8), .OP_W(OP_W)) bus8 ();
  calc_if #(.W(W4), .OP_W(OP_W)) bus4 ();

  arith_calc_seq #(.W(W8), .OP_W(OP_W)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  arith_calc_seq #(.W(W4), .OP_W(OP_W)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic compare(input exp_t e, input logic [15:0] res, input logic err, input int lat);
    check({e.name, "_result"}, res, e.res);
    check({e.name, "_error"}, {15'd0, err}, {15'd0, e.err});
    total++;
    if (e.lat_max ? (lat > e.lat || lat < 2) : (lat != e.lat)) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %s%0d", e.name, lat, e.lat_max ? "<=" : "", e.lat);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (bus8.done) begin
      if (exp_q8.size() == 0) begin
        total++; bad++;
        $display("FAIL w8_unexpected_done: got done=1 want no pending op");
      end else begin
        e8 = exp_q8.pop_front();
        compare(e8, bus8.result, bus8.error, cyc - e8.acc);
      end
    end
  end

  always @(negedge clk) begin
    if (bus4.done) begin
      if (exp_q4.size() == 0) begin
        total++; bad++;
        $display("FAIL w4_unexpected_done: got done=1 want no pending op");
      end else begin
        e4 = exp_q4.pop_front();
        compare(e4, {8'd0, bus4.result}, bus4.error, cyc - e4.acc);
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic wait_idle8();
    int i = 0;
    while ((exp_q8.size() != 0 || bus8.busy || bus8.done) && i < 200) begin
      @(negedge clk); i++;
    end
    if (i >= 200) begin
      total++; bad++;
      $display("FAIL w8_timeout: got busy after %0d cycles want idle", i);
      exp_q8.delete();
    end
  endtask

  task automatic wait_idle4();
    int i = 0;
    while ((exp_q4.size() != 0 || bus4.busy || bus4.done) && i < 200) begin
      @(negedge clk); i++;
    end
    if (i >= 200) begin
      total++; bad++;
      $display("FAIL w4_timeout: got busy after %0d cycles want idle", i);
      exp_q4.delete();
    end
  endtask

  task automatic issue8(input string name, input int unsigned op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] res, input logic err,
                        input int lat, input bit lat_max, input bit push);
    exp_t e;
    wait_idle8();
    bus8.opcode    = 4'(op);
    bus8.operand_a = a;
    bus8.operand_b = b;
    bus8.start     = 1'b1;
    if (push) begin
      e = '{name: name, res: res, err: err, lat: lat, lat_max: lat_max, acc: cyc + 1};
      exp_q8.push_back(e);
    end
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic issue4(input string name, input int unsigned op, input logic [3:0] a,
                        input logic [3:0] b, input logic [7:0] res, input logic err,
                        input int lat, input bit lat_max);
    exp_t e;
    wait_idle4();
    bus4.opcode    = 4'(op);
    bus4.operand_a = a;
    bus4.operand_b = b;
    bus4.start     = 1'b1;
    e = '{name: name, res: {8'd0, res}, err: err, lat: lat, lat_max: lat_max, acc: cyc + 1};
    exp_q4.push_back(e);
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    int i;
    bus8.start = 1'b0; bus8.opcode = '0; bus8.operand_a = '0; bus8.operand_b = '0;
    bus4.start = 1'b0; bus4.opcode = '0; bus4.operand_a = '0; bus4.operand_b = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_result", bus8.result, 16'h0000);
    check("rst_error", {15'd0, bus8.error}, 16'd0);
    check("rst_busy", {15'd0, bus8.busy}, 16'd0);
    check("rst_done", {15'd0, bus8.done}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed vectors, W=8
    issue8("add_200_100", OP_ADD, 8'd200, 8'd100, 16'h012C, 1'b0, 2, 1'b0, 1'b1);
    issue8("sub_5_7",     OP_SUB, 8'd5,   8'd7,   16'h00FE, 1'b0, 2, 1'b0, 1'b1);
    issue8("sub_7_5",     OP_SUB, 8'd7,   8'd5,   16'h0102, 1'b0, 2, 1'b0, 1'b1);
    issue8("mul_m3_4",    OP_MUL, 8'hFD,  8'h04,  16'hFFF4, 1'b0, 10, 1'b0, 1'b1);
    issue8("mul_m3_m4",   OP_MUL, 8'hFD,  8'hFC,  16'h000C, 1'b0, 10, 1'b0, 1'b1);
    issue8("mul_m128sq",  OP_MUL, 8'h80,  8'h80,  16'h4000, 1'b0, 10, 1'b0, 1'b1);
    issue8("mul_127_m128",OP_MUL, 8'h7F,  8'h80,  16'hC080, 1'b0, 10, 1'b0, 1'b1);
    issue8("div_200_7",   OP_DIV, 8'd200, 8'd7,   16'h1C04, 1'b0, 10, 1'b0, 1'b1);
    issue8("div_9_0",     OP_DIV, 8'd9,   8'd0,   16'h0000, 1'b1, 2, 1'b0, 1'b1);
    issue8("div_255_255", OP_DIV, 8'd255, 8'd255, 16'h0100, 1'b0, 10, 1'b0, 1'b1);
    issue8("div_3_200",   OP_DIV, 8'd3,   8'd200, 16'h0003, 1'b0, 10, 1'b0, 1'b1);
    issue8("gcd_96_36",   OP_GCD, 8'd96,  8'd36,  16'h000C, 1'b0, 19, 1'b1, 1'b1);
    issue8("gcd_0_5",     OP_GCD, 8'd0,   8'd5,   16'h0005, 1'b0, 19, 1'b1, 1'b1);
    issue8("gcd_7_0",     OP_GCD, 8'd7,   8'd0,   16'h0007, 1'b0, 19, 1'b1, 1'b1);
    issue8("gcd_0_0",     OP_GCD, 8'd0,   8'd0,   16'h0000, 1'b1, 2, 1'b0, 1'b1);
    issue8("gcd_255_1",   OP_GCD, 8'd255, 8'd1,   16'h0001, 1'b0, 19, 1'b1, 1'b1);
    issue8("gcd_128_128", OP_GCD, 8'd128, 8'd128, 16'h0080, 1'b0, 19, 1'b1, 1'b1);
    issue8("gcd_128_96",  OP_GCD, 8'd128, 8'd96,  16'h0020, 1'b0, 19, 1'b1, 1'b1);
    issue8("and",         OP_AND, 8'hF0,  8'h3C,  16'h0030, 1'b0, 2, 1'b0, 1'b1);
    issue8("or",          OP_OR,  8'hF0,  8'h0F,  16'h00FF, 1'b0, 2, 1'b0, 1'b1);
    issue8("xor",         OP_XOR, 8'hAA,  8'hFF,  16'h0055, 1'b0, 2, 1'b0, 1'b1);
    issue8("op_a",        4'hA,   8'd1,   8'd2,   16'h0000, 1'b1, 2, 1'b0, 1'b1);
    issue8("add_after_err", OP_ADD, 8'd1, 8'd1,   16'h0002, 1'b0, 2, 1'b0, 1'b1);
    issue8("op_f",        4'hF,   8'd3,   8'd4,   16'h0000, 1'b1, 2, 1'b0, 1'b1);

    // start and operand changes while a DIV is running are ignored
    issue8("div_mid",     OP_DIV, 8'd200, 8'd7,   16'h1C04, 1'b0, 10, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    bus8.opcode = 4'(OP_ADD); bus8.operand_a = 8'd1; bus8.operand_b = 8'd1; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0; bus8.operand_a = 8'd50;

    // start during the done cycle is ignored
    issue8("add_fin",     OP_ADD, 8'd1,   8'd2,   16'h0003, 1'b0, 2, 1'b0, 1'b1);
    i = 0;
    while (!bus8.done && i < 20) begin @(negedge clk); i++; end
    check("fin_wait_done", {15'd0, bus8.done}, 16'd1);
    bus8.opcode = 4'(OP_XOR); bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    check("fin_start_busy", {15'd0, bus8.busy}, 16'd0);
    check("fin_start_done", {15'd0, bus8.done}, 16'd0);
    check("fin_result_held", bus8.result, 16'h0003);

    // reset in the middle of a MUL: no done, outputs cleared
    issue8("mul_reset",   OP_MUL, 8'hFD,  8'h04,  16'h0000, 1'b0, 10, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_result", bus8.result, 16'h0000);
    check("midrst_busy", {15'd0, bus8.busy}, 16'd0);
    check("midrst_done", {15'd0, bus8.done}, 16'd0);
    check("midrst_error", {15'd0, bus8.error}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus8.done) dones++;
    end
    check("midrst_no_done", 16'(dones), 16'd0);

    // legacy W=4 vectors
    issue4("w4_div_10_3",  OP_DIV, 4'd10, 4'd3,  8'h31, 1'b0, 6, 1'b0);
    issue4("w4_gcd_8_12",  OP_GCD, 4'd8,  4'd12, 8'h04, 1'b0, 11, 1'b1);
    issue4("w4_xor_12_10", OP_XOR, 4'd12, 4'd10, 8'h06, 1'b0, 2, 1'b0);
    issue4("w4_add_15_15", OP_ADD, 4'd15, 4'd15, 8'h1E, 1'b0, 2, 1'b0);
    issue4("w4_sub_3_5",   OP_SUB, 4'd3,  4'd5,  8'h0E, 1'b0, 2, 1'b0);
    issue4("w4_mul_m3_4",  OP_MUL, 4'hD,  4'h4,  8'hF4, 1'b0, 6, 1'b0);
    issue4("w4_div_by0",   OP_DIV, 4'd9,  4'd0,  8'h00, 1'b1, 2, 1'b0);
    wait_idle4();
    wait_idle8();

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
